// File: rtl/sub_addresses_serial.sv
// rtl/sub_addresses_serial.sv - bit-serial address subtractor, diff = a + ~b + 1, STEP bits per clock
module sub_addresses_serial #(
  parameter int WIDTH = 64,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] sh_a, sh_b, acc, result;
  logic             carry, c_out, c_msb, c;
  logic [CW-1:0]    count;
  logic [STEP-1:0]  sum;
  logic             accept, last;

  assign accept = start && (state != RUN);
  assign last   = (state == RUN) && (count == CW'(N - 1));
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  // Ripple chain over the low STEP bits; c_msb is the carry into the top
  // bit of the chunk, which on the final step is the carry into the MSB.
  always_comb begin
    c     = carry;
    c_msb = carry;
    sum   = '0;
    for (int i = 0; i < STEP; i++) begin
      c_msb  = c;
      sum[i] = sh_a[i] ^ sh_b[i] ^ c;
      c      = (sh_a[i] & sh_b[i]) | (c & (sh_a[i] ^ sh_b[i]));
    end
    c_out  = c;
    result = {sum, acc[WIDTH-1:STEP]};
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_a     <= '0;
      sh_b     <= '0;
      acc      <= '0;
      carry    <= 1'b0;
      count    <= '0;
      diff     <= '0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (accept) begin
      sh_a  <= a;
      sh_b  <= ~b;
      carry <= 1'b1;
      count <= '0;
    end else if (state == RUN) begin
      acc   <= result;
      sh_a  <= sh_a >> STEP;
      sh_b  <= sh_b >> STEP;
      carry <= c_out;
      count <= count + CW'(1);
      // Ports change only here, so partial sums never become visible.
      if (last) begin
        diff     <= result;
        borrow   <= ~c_out;
        overflow <= c_msb ^ c_out;
        zero     <= (result == '0);
      end
    end
  end

endmodule

// File: doc/sub_addresses_serial.md
Name: sub_addresses_serial

Overview:
- Multi-cycle 64-bit address subtractor. It computes diff = a - b by two's-complement addition a + ~b + 1, processing STEP bits per clock from LSB upward with one registered carry.
- It is the inverse-direction companion of the combinational address adder. It serves branch-distance and bounds checks (target - PC, limit - addr) where one result every N cycles is sufficient.
- Start/done handshake with busy. Result and flags are held stable until the next accepted start.

Parameters:
WIDTH, 64, operand/result width in bits
STEP, 1, bits processed per clock; must divide WIDTH evenly; N = WIDTH/STEP compute cycles

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only when busy=0
a  input  WIDTH  minuend; sampled on the accepting edge only
b  input  WIDTH  subtrahend; sampled on the accepting edge only
busy  output  1  high while a subtraction is in progress
done  output  1  one-cycle pulse: diff and flags valid
diff  output  WIDTH  a - b modulo 2^WIDTH
borrow  output  1  1 when a < b unsigned (i.e. final carry-out = 0)
overflow  output  1  signed overflow: carry into MSB xor carry out of MSB
zero  output  1  diff == 0

Behaviour:
- Reset, checked at the clock edge: state=IDLE; busy=0, done=0, diff=0, borrow=0, overflow=0, zero=0; internal count=0, carry=0. Reset has priority over everything, including mid-RUN; any partial result is discarded.
- States:
  - IDLE: wait for start.
  - RUN: compute.
  - DONE: one cycle; done=1.
- Accept: at edge t0 with start=1 and state in {IDLE, DONE}:
  - latch a into shift register A and ~b into shift register B;
  - set carry=1 and count=0;
  - go to RUN; busy=1 after t0.
- start while busy=1 is ignored and not queued. Operand changes during RUN have no effect.
- RUN, each edge:
  - add the low STEP bits of A, B and carry with a ripple chain;
  - shift the sum bits into the top of the diff shift register and shift A and B right by STEP;
  - carry <= chain carry-out; count++.
  - On the final step, capture the carry into the MSB as well, to form overflow.
- After the Nth RUN edge (edge t0+N):
  - state=DONE; busy=0; done=1 for exactly that one cycle;
  - diff holds the full result;
  - borrow = ~carry_out; overflow = c_in(MSB) ^ c_out(MSB); zero = (diff == 0).
- Latency from accepting edge to done: N cycles (64 for default; 16 for STEP=4).
- DONE -> IDLE on the next edge if start=0. DONE -> RUN if start=1, giving back-to-back throughput of one result per N+1 cycles.
- diff, borrow, overflow and zero:
  - hold their values through IDLE and the next RUN until overwritten at the next done;
  - never show partial results on the ports. The shift register is internal, and the output registers update only on the DONE transition.
- Wrap-around: arithmetic is modulo 2^WIDTH; no saturation.

Test Plan:
- Reset, then a=0x10, b=0x4, start for 1 cycle -> busy high 64 cycles; done pulse at edge t0+64; diff=0xC, borrow=0, overflow=0, zero=0.
- a=0x0, b=0x1 -> diff=0xFFFF_FFFF_FFFF_FFFF, borrow=1, overflow=0. Then a=b=0x4000_0000_0000_1234 -> diff=0, zero=1, borrow=0.
- a=0x8000_0000_0000_0000, b=1 -> diff=0x7FFF_FFFF_FFFF_FFFF, overflow=1, borrow=0. a=0x7FFF_FFFF_FFFF_FFFF, b=0xFFFF_FFFF_FFFF_FFFF -> diff=0x8000_0000_0000_0000, overflow=1, borrow=1.
- Start pulsed at cycle 10 of RUN with different operands, and a/b changed mid-RUN -> ignored; first result unaffected. Start held high through DONE -> new op accepted; next done exactly 65 cycles after previous done.
- Reset asserted at RUN cycle 30 -> next cycle busy=0, done=0, diff=0, state IDLE; a fresh start then completes correctly in 64 cycles.
- STEP=4 instance, 1000 random a/b pairs -> done 16 cycles after each accept; diff == a-b and borrow == (a<b) every time.
